// File: rtl/led_breathe_pwm.sv
// led_breathe_pwm
//   PWM brightness stage for one LED. Produces breathing (triangle ramp with
//   holds at top and bottom), solid-on and blink patterns. The PWM comparator
//   only picks up a new duty at the counter wrap, so no period mixes two duties.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset (synchronous release upstream)
//   en         block enable
//   mode       pattern select: 0 off, 1 solid, 2 breathe, 3 blink
//   led        registered PWM LED drive
//   duty       duty currently applied to the PWM comparator
//   state      FSM state: IDLE=0, UP=1, TOP=2, DOWN=3, BOT=4
//   step_tick  one-cycle pulse per brightness step
module led_breathe_pwm #(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned STEP_CYCLES = 48828,
  parameter int unsigned HOLD_STEPS  = 64,
  parameter int unsigned BLINK_STEPS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [1:0]          mode,
  output logic                led,
  output logic [PWM_BITS-1:0] duty,
  output logic [2:0]          state,
  output logic                step_tick
);

  // Counter widths. The hold counter serves both the breathe holds and the
  // blink half-period, so it is sized for the larger of the two.
  localparam int unsigned PrescW  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int unsigned HoldMax = (HOLD_STEPS > BLINK_STEPS) ? HOLD_STEPS : BLINK_STEPS;
  localparam int unsigned HoldW   = (HoldMax > 1) ? $clog2(HoldMax) : 1;

  localparam logic [PWM_BITS-1:0] DutyMax   = '1;
  localparam logic [PWM_BITS-1:0] DutyZero  = '0;
  localparam logic [PWM_BITS-1:0] DutyOne   = PWM_BITS'(1);
  localparam logic [PrescW-1:0]   PrescLast = PrescW'(STEP_CYCLES - 1);
  localparam logic [PrescW-1:0]   PrescOne  = PrescW'(1);
  localparam logic [HoldW-1:0]    HoldLast  = HoldW'(HOLD_STEPS - 1);
  localparam logic [HoldW-1:0]    BlinkLast = HoldW'(BLINK_STEPS - 1);
  localparam logic [HoldW-1:0]    HoldOne   = HoldW'(1);

  localparam logic [1:0] ModeOff     = 2'd0;
  localparam logic [1:0] ModeSolid   = 2'd1;
  localparam logic [1:0] ModeBreathe = 2'd2;
  localparam logic [1:0] ModeBlink   = 2'd3;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StUp   = 3'd1,
    StTop  = 3'd2,
    StDown = 3'd3,
    StBot  = 3'd4
  } state_e;

  state_e              state_q;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [PWM_BITS-1:0] duty_q;
  logic [PWM_BITS-1:0] duty_next_q;
  logic [PrescW-1:0]   presc_q;
  logic [HoldW-1:0]    hold_q;
  logic [1:0]          mode_q;
  logic                led_q;

  logic run;
  logic mode_chg;
  logic presc_active;
  logic tick;
  logic pwm_wrap;
  logic solid_on;

  assign run = en && (mode != ModeOff);

  // A mode change only matters once the FSM has left IDLE; entering from
  // IDLE always goes straight to the start state of the selected mode.
  assign mode_chg = run && (state_q != StIdle) && (mode != mode_q);

  // Only breathe and blink step; a pending mode change (or disable) beats a
  // tick landing in the same cycle.
  assign presc_active = run && mode[1] && !mode_chg;
  assign tick         = presc_active && (presc_q == PrescLast);

  assign pwm_wrap = (pwm_cnt_q == DutyMax);
  assign solid_on = run && !mode_chg && (mode == ModeSolid) && (state_q == StTop);

  assign led       = led_q;
  assign duty      = duty_q;
  assign state     = state_q;
  assign step_tick = tick;

  // PWM counter, duty latch and LED compare. Free-runs out of reset
  // regardless of en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      duty_q    <= '0;
      led_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + DutyOne;
      // duty_next_q is the pre-edge value: a step landing on the wrap edge
      // shows up at the following wrap.
      if (pwm_wrap) begin
        duty_q <= duty_next_q;
      end
      led_q <= solid_on || (pwm_cnt_q < duty_q);
    end
  end

  // Prescaler and pattern FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      duty_next_q <= '0;
      presc_q     <= '0;
      hold_q      <= '0;
      mode_q      <= ModeOff;
    end else begin
      mode_q <= mode;

      if (!presc_active) begin
        presc_q <= '0;
      end else if (tick) begin
        presc_q <= '0;
      end else begin
        presc_q <= presc_q + PrescOne;
      end

      if (!run || mode_chg) begin
        state_q     <= StIdle;
        duty_next_q <= '0;
        hold_q      <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            hold_q <= '0;
            unique case (mode)
              ModeSolid: begin
                state_q     <= StTop;
                duty_next_q <= DutyMax;
              end
              ModeBreathe: begin
                state_q     <= StUp;
                duty_next_q <= DutyZero;
              end
              ModeBlink: begin
                state_q     <= StTop;
                duty_next_q <= DutyMax;
              end
              default: begin
                state_q     <= StIdle;
                duty_next_q <= DutyZero;
              end
            endcase
          end

          StUp: begin
            if (tick) begin
              if (duty_next_q == DutyMax) begin
                state_q <= StTop;
                hold_q  <= '0;
              end else begin
                duty_next_q <= duty_next_q + DutyOne;
              end
            end
          end

          StDown: begin
            if (tick) begin
              if (duty_next_q == DutyZero) begin
                state_q <= StBot;
                hold_q  <= '0;
              end else begin
                duty_next_q <= duty_next_q - DutyOne;
              end
            end
          end

          // TOP/BOT: breathe holds then ramps the other way; blink toggles
          // between full and zero. Solid never ticks, so it rests in TOP.
          StTop, StBot: begin
            if (tick) begin
              if (mode == ModeBlink) begin
                if (hold_q == BlinkLast) begin
                  hold_q      <= '0;
                  state_q     <= (state_q == StTop) ? StBot : StTop;
                  duty_next_q <= (state_q == StTop) ? DutyZero : DutyMax;
                end else begin
                  hold_q <= hold_q + HoldOne;
                end
              end else begin
                if (hold_q == HoldLast) begin
                  hold_q  <= '0;
                  state_q <= (state_q == StTop) ? StDown : StUp;
                end else begin
                  hold_q <= hold_q + HoldOne;
                end
              end
            end
          end

          default: begin
            state_q     <= StIdle;
            duty_next_q <= '0;
            hold_q      <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_breathe_pwm.sv
// Directed bench for led_breathe_pwm with PWM_BITS=4, STEP_CYCLES=4,
// HOLD_STEPS=2, BLINK_STEPS=3. Inputs change and outputs are sampled on the
// falling clock edge; n counts rising edges after the stimulus change.
module tb_led_breathe_pwm;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic       led;
  logic [3:0] duty;
  logic [2:0] state;
  logic       step_tick;

  int n_checks;
  int n_fails;

  // Rising edges since reset release; tracks the expected pwm counter phase.
  int unsigned cyc;

  logic       led_log  [0:160];
  logic [3:0] duty_log [0:160];
  logic [2:0] st_log   [0:160];

  led_breathe_pwm #(
    .PWM_BITS   (4),
    .STEP_CYCLES(4),
    .HOLD_STEPS (2),
    .BLINK_STEPS(3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .led      (led),
    .duty     (duty),
    .state    (state),
    .step_tick(step_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000 ns, required to finish earlier");
    $fatal(1, "watchdog expired");
  end

  // Park the block with en low long enough for duty to settle at 0, then
  // start the given mode at a chosen pwm counter phase.
  task automatic start_mode(input logic [1:0] m, input int unsigned phase);
    en   = 1'b0;
    mode = 2'd0;
    repeat (20) @(negedge clk);
    while ((cyc % 16) != phase) @(negedge clk);
    en   = 1'b1;
    mode = m;
  endtask

  task automatic test_reset();
    int bad_out;
    int bad_cnt;
    int wraps;
    rst_n = 1'b0;
    en    = 1'b0;
    mode  = 2'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (led !== 1'b0) begin n_fails++; $display("FAIL reset_led: got %b, expected 0", led); end
    n_checks++;
    if (duty !== 4'd0) begin n_fails++; $display("FAIL reset_duty: got %0d, expected 0", duty); end
    n_checks++;
    if (state !== 3'd0) begin n_fails++; $display("FAIL reset_state: got %0d, expected 0", state); end
    n_checks++;
    if (step_tick !== 1'b0) begin n_fails++; $display("FAIL reset_tick: got %b, expected 0", step_tick); end

    rst_n   = 1'b1;
    bad_out = 0;
    bad_cnt = 0;
    wraps   = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (led !== 1'b0 || duty !== 4'd0 || state !== 3'd0 || step_tick !== 1'b0) bad_out++;
      if (dut.pwm_cnt_q !== 4'(cyc % 16)) bad_cnt++;
      if (dut.pwm_cnt_q === 4'd0) wraps++;
    end
    n_checks++;
    if (bad_out != 0) begin n_fails++; $display("FAIL idle_outputs: %0d nonzero cycles, expected 0", bad_out); end
    n_checks++;
    if (bad_cnt != 0) begin n_fails++; $display("FAIL idle_pwm_count: %0d off-phase cycles, expected 0", bad_cnt); end
    n_checks++;
    if (wraps != 6) begin n_fails++; $display("FAIL idle_pwm_wraps: got %0d, expected 6", wraps); end
  endtask

  task automatic test_breathe();
    int first_tick, ticks, first_top, first_down, first_bot, first_up2, bad_wrap;
    logic [3:0] peak;
    logic [3:0] prev_duty;
    start_mode(2'd2, 8);
    first_tick = -1; first_top = -1; first_down = -1; first_bot = -1; first_up2 = -1;
    ticks = 0; bad_wrap = 0; peak = 4'd0; prev_duty = duty;
    for (int n = 1; n <= 160; n++) begin
      @(negedge clk);
      led_log[n]  = led;
      duty_log[n] = duty;
      st_log[n]   = state;
      if (step_tick === 1'b1) begin
        ticks++;
        if (first_tick < 0) first_tick = n;
      end
      if (state === 3'd2 && first_top < 0) first_top = n;
      if (state === 3'd3 && first_down < 0) first_down = n;
      if (state === 3'd4 && first_bot < 0) first_bot = n;
      if (first_bot >= 0 && state === 3'd1 && first_up2 < 0) first_up2 = n;
      if (duty !== prev_duty && (cyc % 16) != 0) bad_wrap++;
      if (duty > peak) peak = duty;
      prev_duty = duty;
    end
    n_checks++;
    if (st_log[1] !== 3'd1) begin n_fails++; $display("FAIL breathe_enter_up: state=%0d, expected 1", st_log[1]); end
    n_checks++;
    if (first_tick != 3) begin n_fails++; $display("FAIL breathe_first_tick: at %0d, expected 3", first_tick); end
    n_checks++;
    if (ticks != 40) begin n_fails++; $display("FAIL breathe_tick_count: got %0d, expected 40", ticks); end
    n_checks++;
    if (first_top != 64) begin n_fails++; $display("FAIL breathe_top: at %0d, expected 64", first_top); end
    n_checks++;
    if (first_down != 72) begin n_fails++; $display("FAIL breathe_down: at %0d, expected 72", first_down); end
    n_checks++;
    if (first_bot != 136) begin n_fails++; $display("FAIL breathe_bot: at %0d, expected 136", first_bot); end
    n_checks++;
    if (first_up2 != 144) begin n_fails++; $display("FAIL breathe_up_again: at %0d, expected 144", first_up2); end
    n_checks++;
    if (bad_wrap != 0) begin n_fails++; $display("FAIL breathe_duty_on_wrap: %0d mid-period changes, expected 0", bad_wrap); end
    n_checks++;
    if (peak !== 4'd15) begin n_fails++; $display("FAIL breathe_peak: got %0d, expected 15", peak); end
    n_checks++;
    if (duty_log[40] !== 4'd9) begin n_fails++; $display("FAIL breathe_tick_on_wrap: duty=%0d, expected 9", duty_log[40]); end
  endtask

  task automatic test_pwm_duty();
    int highs5, highs15, highs0;
    highs5 = 0; highs15 = 0; highs0 = 0;
    for (int n = 25; n <= 40; n++) if (led_log[n] === 1'b1) highs5++;
    for (int n = 73; n <= 88; n++) if (led_log[n] === 1'b1) highs15++;
    for (int n = 137; n <= 152; n++) if (led_log[n] === 1'b1) highs0++;
    n_checks++;
    if (duty_log[24] !== 4'd5) begin n_fails++; $display("FAIL pwm_duty5_load: duty=%0d, expected 5", duty_log[24]); end
    n_checks++;
    if (highs5 != 5) begin n_fails++; $display("FAIL pwm_duty5_highs: got %0d, expected 5", highs5); end
    n_checks++;
    if (led_log[24] !== 1'b0 || led_log[25] !== 1'b1 || led_log[29] !== 1'b1 || led_log[30] !== 1'b0) begin
      n_fails++;
      $display("FAIL pwm_duty5_edges: led[24,25,29,30]=%b%b%b%b, expected 0110",
               led_log[24], led_log[25], led_log[29], led_log[30]);
    end
    n_checks++;
    if (duty_log[72] !== 4'd15) begin n_fails++; $display("FAIL pwm_duty15_load: duty=%0d, expected 15", duty_log[72]); end
    n_checks++;
    if (highs15 != 15) begin n_fails++; $display("FAIL pwm_duty15_highs: got %0d, expected 15", highs15); end
    n_checks++;
    if (duty_log[136] !== 4'd0) begin n_fails++; $display("FAIL pwm_duty0_load: duty=%0d, expected 0", duty_log[136]); end
    n_checks++;
    if (highs0 != 0) begin n_fails++; $display("FAIL pwm_duty0_highs: got %0d, expected 0", highs0); end
    n_checks++;
    if (duty_log[152] !== 4'd1) begin n_fails++; $display("FAIL pwm_duty_after_bot: duty=%0d, expected 1", duty_log[152]); end
  endtask

  task automatic test_solid();
    int highs;
    start_mode(2'd1, cyc % 16);
    @(negedge clk);
    n_checks++;
    if (state !== 3'd2) begin n_fails++; $display("FAIL solid_state: got %0d, expected 2", state); end
    n_checks++;
    if (led !== 1'b0) begin n_fails++; $display("FAIL solid_first_edge: led=%b, expected 0", led); end
    highs = 0;
    for (int n = 2; n <= 40; n++) begin
      @(negedge clk);
      if (led === 1'b1) highs++;
    end
    n_checks++;
    if (highs != 39) begin n_fails++; $display("FAIL solid_led_on: got %0d high cycles, expected 39", highs); end
    n_checks++;
    if (duty !== 4'd15) begin n_fails++; $display("FAIL solid_duty: got %0d, expected 15", duty); end
  endtask

  task automatic test_blink();
    int first_tick;
    start_mode(2'd3, 12);
    first_tick = -1;
    for (int n = 1; n <= 70; n++) begin
      @(negedge clk);
      duty_log[n] = duty;
      st_log[n]   = state;
      if (step_tick === 1'b1 && first_tick < 0) first_tick = n;
    end
    n_checks++;
    if (first_tick != 3) begin n_fails++; $display("FAIL blink_first_tick: at %0d, expected 3", first_tick); end
    n_checks++;
    if (st_log[1] !== 3'd2 || st_log[11] !== 3'd2) begin
      n_fails++; $display("FAIL blink_top: state[1,11]=%0d,%0d, expected 2,2", st_log[1], st_log[11]);
    end
    n_checks++;
    if (st_log[12] !== 3'd4 || st_log[23] !== 3'd4) begin
      n_fails++; $display("FAIL blink_bot: state[12,23]=%0d,%0d, expected 4,4", st_log[12], st_log[23]);
    end
    n_checks++;
    if (st_log[24] !== 3'd2 || st_log[36] !== 3'd4) begin
      n_fails++; $display("FAIL blink_toggle: state[24,36]=%0d,%0d, expected 2,4", st_log[24], st_log[36]);
    end
    n_checks++;
    if (duty_log[3] !== 4'd0 || duty_log[4] !== 4'd15) begin
      n_fails++; $display("FAIL blink_duty_on: duty[3,4]=%0d,%0d, expected 0,15", duty_log[3], duty_log[4]);
    end
    n_checks++;
    if (duty_log[20] !== 4'd0) begin n_fails++; $display("FAIL blink_duty_off: duty=%0d, expected 0", duty_log[20]); end
    n_checks++;
    if (duty_log[36] !== 4'd15) begin n_fails++; $display("FAIL blink_tick_on_wrap: duty=%0d, expected 15", duty_log[36]); end
    n_checks++;
    if (duty_log[68] !== 4'd0) begin n_fails++; $display("FAIL blink_duty_late: duty=%0d, expected 0", duty_log[68]); end
  endtask

  task automatic test_mode_switch();
    start_mode(2'd2, 8);
    repeat (29) @(negedge clk);
    n_checks++;
    if (dut.duty_next_q !== 4'd7) begin n_fails++; $display("FAIL switch_pre_ramp: duty_next=%0d, expected 7", dut.duty_next_q); end
    mode = 2'd3;
    @(negedge clk);
    n_checks++;
    if (state !== 3'd0) begin n_fails++; $display("FAIL switch_idle: state=%0d, expected 0", state); end
    n_checks++;
    if (dut.duty_next_q !== 4'd0 || dut.presc_q !== 2'd0) begin
      n_fails++; $display("FAIL switch_idle_clear: duty_next=%0d presc=%0d, expected 0 0", dut.duty_next_q, dut.presc_q);
    end
    n_checks++;
    if (duty !== 4'd5) begin n_fails++; $display("FAIL switch_duty_hold: duty=%0d, expected 5", duty); end
    @(negedge clk);
    n_checks++;
    if (state !== 3'd2 || dut.duty_next_q !== 4'd15) begin
      n_fails++; $display("FAIL switch_blink_top: state=%0d duty_next=%0d, expected 2 15", state, dut.duty_next_q);
    end
    @(negedge clk);
    n_checks++;
    if (step_tick !== 1'b0) begin n_fails++; $display("FAIL switch_tick_early: got %b, expected 0", step_tick); end
    @(negedge clk);
    n_checks++;
    if (step_tick !== 1'b1) begin n_fails++; $display("FAIL switch_tick_restart: got %b, expected 1", step_tick); end
    repeat (7) @(negedge clk);
    n_checks++;
    if (duty !== 4'd15) begin n_fails++; $display("FAIL switch_duty_apply: duty=%0d, expected 15", duty); end
  endtask

  task automatic test_en_drop_tick();
    logic       found;
    logic [3:0] d0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (step_tick === 1'b1 && (cyc % 16) != 15) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fails++; $display("FAIL en_drop_wait: no step_tick within 100 cycles, expected one");
    end else begin
      d0 = duty;
      en = 1'b0;
      #1;
      n_checks++;
      if (step_tick !== 1'b0) begin n_fails++; $display("FAIL en_drop_tick_masked: got %b, expected 0", step_tick); end
      @(negedge clk);
      n_checks++;
      if (state !== 3'd0) begin n_fails++; $display("FAIL en_drop_idle: state=%0d, expected 0", state); end
      n_checks++;
      if (duty !== d0) begin n_fails++; $display("FAIL en_drop_duty: got %0d, expected %0d", duty, d0); end
      n_checks++;
      if (dut.duty_next_q !== 4'd0) begin n_fails++; $display("FAIL en_drop_next: got %0d, expected 0", dut.duty_next_q); end
    end
  endtask

  task automatic test_reset_mid();
    start_mode(2'd2, 8);
    repeat (76) @(negedge clk);
    n_checks++;
    if (state !== 3'd3 || duty !== 4'd15 || led !== 1'b1) begin
      n_fails++; $display("FAIL midreset_pre: state=%0d duty=%0d led=%b, expected 3 15 1", state, duty, led);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (led !== 1'b0 || duty !== 4'd0 || state !== 3'd0 || step_tick !== 1'b0) begin
      n_fails++;
      $display("FAIL midreset_async: led=%b duty=%0d state=%0d tick=%b, expected 0 0 0 0",
               led, duty, state, step_tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b0;
    mode  = 2'd0;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    mode     = 2'd0;
    test_reset();
    test_breathe();
    test_pwm_duty();
    test_solid();
    test_blink();
    test_mode_switch();
    test_en_drop_tick();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
